// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges main W-stage results and late multiplier results onto one RF write port.
// Define WB_BYPASS_EN to let a multiplier result write directly when the pending FIFO is empty.
module writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [DW-1:0] ReadDataW,
  input  logic [DW-1:0] ALUOutW,
  input  logic [DW-1:0] FloatoutW,
  input  logic          Float_startW,
  input  logic          MemtoRegW,
  input  logic          RegWriteW,
  input  logic          PCSrcW,
  input  logic [AW-1:0] WA3W,
  input  logic          MvalidW,
  input  logic [AW-1:0] MWA3W,
  input  logic [DW-1:0] WResultW,
  output logic [DW-1:0] ResultW,
  output logic          PCWrEn,
  output logic          WE3,
  output logic [AW-1:0] WA3,
  output logic [DW-1:0] WD3,
  output logic          MulStall,
  output logic          Overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             head_present, head_valid, byp, pop, push_req, push, full;
  assign ResultW      = MemtoRegW ? ReadDataW : Float_startW ? FloatoutW : ALUOutW;
  assign PCWrEn       = PCSrcW;
  assign head_present = count_q != '0;
  assign head_valid   = head_present & valid_q[rd_ptr_q];
`ifdef WB_BYPASS_EN
  assign byp = MvalidW & ~RegWriteW & ~head_present;
`else
  assign byp = 1'b0;
`endif
  // The head slot is consumed whenever the main path leaves the port free, valid or cancelled.
  assign pop      = ~RegWriteW & head_present;
  assign push_req = MvalidW & ~(RegWriteW & (MWA3W == WA3W)) & ~byp;
  assign full     = count_q == CW'(DEPTH);
  assign push     = push_req & (~full | pop);
  assign count_d  = count_q + CW'(push) - CW'(pop);
  assign ovf_d    = ovf_q | (push_req & full & ~pop);
  assign WE3      = RegWriteW | head_valid | byp;
  assign WA3      = RegWriteW ? WA3W : head_valid ? addr_q[rd_ptr_q] : byp ? MWA3W : '0;
  assign WD3      = RegWriteW ? ResultW : head_valid ? data_q[rd_ptr_q] : byp ? WResultW : '0;
  assign MulStall = count_q >= CW'(DEPTH - 1);
  assign Overflow = ovf_q;
  // A main write supersedes every older pending result to the same register.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++)
      if (RegWriteW && addr_q[i] == WA3W) valid_d[i] = 1'b0;
    if (push) valid_d[wr_ptr_q] = 1'b1;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_q[wr_ptr_q] <= MWA3W;
      data_q[wr_ptr_q] <= WResultW;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: checks writeback_arbiter against a queue-based model of the pending results.
module tb_writeback_arbiter;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;
  logic        CLK = 1'b0, RESET = 1'b1;
  logic [31:0] ReadDataW = '0, ALUOutW = '0, FloatoutW = '0, WResultW = '0;
  logic        Float_startW = 1'b0, MemtoRegW = 1'b0, RegWriteW = 1'b0, PCSrcW = 1'b0, MvalidW = 1'b0;
  logic [3:0]  WA3W = '0, MWA3W = '0;
  logic [31:0] ResultW, WD3;
  logic        PCWrEn, WE3, MulStall, Overflow;
  logic [3:0]  WA3;
  writeback_arbiter #(.DEPTH(DEPTH), .AW(4), .DW(32)) dut (
    .CLK(CLK), .RESET(RESET), .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .FloatoutW(FloatoutW),
    .Float_startW(Float_startW), .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW), .PCSrcW(PCSrcW),
    .WA3W(WA3W), .MvalidW(MvalidW), .MWA3W(MWA3W), .WResultW(WResultW), .ResultW(ResultW),
    .PCWrEn(PCWrEn), .WE3(WE3), .WA3(WA3), .WD3(WD3), .MulStall(MulStall), .Overflow(Overflow));
  always #5 CLK = ~CLK;
  typedef struct {logic [3:0] a; logic [31:0] d; bit v;} ent_t;
  ent_t        q[$];
  bit          m_ovf;
  logic [31:0] rf [16];
  bit          pend_we;
  logic [3:0]  pend_a;
  logic [31:0] pend_d;
  int          errors = 0, checks = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic set_in(input bit rw, input logic [3:0] wa, input bit mem, input bit fl,
                        input bit mv, input logic [3:0] mwa, input logic [31:0] wr);
    RegWriteW = rw; WA3W = wa; MemtoRegW = mem; Float_startW = fl;
    MvalidW = mv; MWA3W = mwa; WResultW = wr;
    ReadDataW = $urandom; ALUOutW = $urandom; FloatoutW = $urandom; PCSrcW = 1'($urandom);
  endtask
  function automatic bit bypass_now();
    return BYP && MvalidW && !RegWriteW && q.size() == 0;
  endfunction
  task automatic model_check();
    logic [31:0] res, wd;
    logic [3:0]  wa;
    bit          we;
    res = MemtoRegW ? ReadDataW : Float_startW ? FloatoutW : ALUOutW;
    if (RegWriteW) begin we = 1; wa = WA3W; wd = res; end
    else if (q.size() > 0 && q[0].v) begin we = 1; wa = q[0].a; wd = q[0].d; end
    else if (bypass_now()) begin we = 1; wa = MWA3W; wd = WResultW; end
    else begin we = 0; wa = 0; wd = 0; end
    chk("ResultW", ResultW, res);
    chk("PCWrEn", 32'(PCWrEn), 32'(PCSrcW));
    chk("WE3", 32'(WE3), 32'(we));
    chk("WA3", 32'(WA3), 32'(wa));
    chk("WD3", WD3, wd);
    chk("MulStall", 32'(MulStall), 32'(q.size() >= DEPTH - 1));
    chk("Overflow", 32'(Overflow), 32'(m_ovf));
    pend_we = we; pend_a = wa; pend_d = wd;
  endtask
  task automatic model_update();
    bit pop, push_req;
    int n;
    n = q.size();
    pop = !RegWriteW && n > 0;
    push_req = MvalidW && !(RegWriteW && MWA3W == WA3W) && !bypass_now();
    if (RegWriteW) foreach (q[i]) if (q[i].a == WA3W) q[i].v = 0;
    if (pop) void'(q.pop_front());
    if (push_req) begin
      if (n < DEPTH || pop) q.push_back('{MWA3W, WResultW, 1'b1});
      else m_ovf = 1;
    end
    if (pend_we) rf[pend_a] = pend_d;
  endtask
  task automatic step();
    #1 model_check();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask
  task automatic areset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #2 RESET = 1'b1;
    #1 chk("areset_stall", 32'(MulStall), 0);
    chk("areset_ovf", 32'(Overflow), 0);
    chk("areset_we", 32'(WE3), 0);
    q.delete(); m_ovf = 0;
    #1 RESET = 1'b0;
    @(negedge CLK);
  endtask
  initial begin
    foreach (rf[i]) rf[i] = '0;
    m_ovf = 0;
    repeat (2) @(negedge CLK);
    chk("rst_we", 32'(WE3), 0);
    chk("rst_stall", 32'(MulStall), 0);
    chk("rst_ovf", 32'(Overflow), 0);
    RESET = 1'b0;
    // main write selection
    set_in(1, 3, 1, 0, 0, 0, 0); ReadDataW = 32'hDEAD0001;
    #1 chk("t1_we", 32'(WE3), 1); chk("t1_wa", 32'(WA3), 3); chk("t1_wd", WD3, 32'hDEAD0001);
    step();
    set_in(1, 3, 0, 1, 0, 0, 0); FloatoutW = 32'hF10A7000;
    #1 chk("t1f_wd", WD3, 32'hF10A7000);
    step();
    // collision then drain
    set_in(1, 2, 0, 0, 1, 5, 32'h55);
    #1 chk("t2_wa0", 32'(WA3), 2);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1 chk("t2_we1", 32'(WE3), 1); chk("t2_wa1", 32'(WA3), 5); chk("t2_wd1", WD3, 32'h55);
    step();
    #1 chk("t2_empty", 32'(WE3), 0);
    step();
    // cancel
    set_in(1, 1, 0, 0, 1, 7, 32'h11); step();
    set_in(1, 7, 0, 0, 0, 0, 0); ALUOutW = 32'h22; step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1 chk("t3_cancel_we", 32'(WE3), 0);
    step(); step();
    chk("t3_r7", rf[7], 32'h22);
    // fill, overflow, ordered drain
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 0, 1, 4'(8 + i), 32'(100 + i));
      if (i == 3) #1 chk("t4_stall3", 32'(MulStall), 1);
      step();
    end
    chk("t4_ovf", 32'(Overflow), 1);
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0);
      #1 chk("t4_drain_wa", 32'(WA3), 32'(8 + i)); chk("t4_drain_wd", WD3, 32'(100 + i));
      step();
    end
    // async reset with pending entries
    for (int i = 0; i < 3; i++) begin set_in(1, 0, 0, 0, 1, 4'(2 + i), 32'(i)); step(); end
    #1 chk("t5_pre_stall", 32'(MulStall), 1);
    areset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1 chk("t5_idle_we", 32'(WE3), 0);
    step();
    // empty FIFO multiplier latency
    set_in(0, 0, 0, 0, 1, 9, 32'h99);
    #1 chk("t6_we0", 32'(WE3), 32'(BYP)); if (BYP) chk("t6_wa0", 32'(WA3), 9);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1 chk("t6_we1", 32'(WE3), 32'(!BYP)); if (!BYP) chk("t6_wa1", 32'(WA3), 9);
    step();
    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) areset();
      set_in(1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 1'($urandom), 1'($urandom),
             $urandom_range(0, 9) < 6, 4'($urandom_range(0, 5)), $urandom);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
